// File: rtl/flasher_pkg.sv
// Shared phase codes and default geometry for the bound-flasher lamp bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Phase codes are also consumed by the output decoder that turns them into
// idle / increment / decrement commands, so their values are fixed.
package flasher_pkg;

  typedef logic [2:0] phase_t;

  localparam phase_t PH_IDLE    = 3'd0;  // waiting for flick, no lamps lit
  localparam phase_t PH_ON_A    = 3'd1;  // first fill up to BOUND_A
  localparam phase_t PH_OFF_A   = 3'd2;  // drain back to zero
  localparam phase_t PH_ON_B    = 3'd3;  // fill up to BOUND_B (kickback-able)
  localparam phase_t PH_OFF_B   = 3'd4;  // drain back to BOUND_A
  localparam phase_t PH_ON_ALL  = 3'd5;  // fill the whole bank (kickback-able)
  localparam phase_t PH_OFF_ALL = 3'd6;  // final drain to zero

  localparam int DEF_N_LAMP  = 16;
  localparam int DEF_BOUND_A = 6;
  localparam int DEF_BOUND_B = 11;

endpackage

// File: rtl/lamp_therm.sv
// Thermometer decoder: lamp[i] is lit iff i < cnt.
// Latency: combinational, zero cycles.
// Backpressure: none.
//
// Ports:
//   cnt   in  CW      number of lit lamps (0..N_LAMP)
//   lamp  out N_LAMP  thermometer-coded lamp vector
module lamp_therm #(
  parameter int N_LAMP = 16,
  parameter int CW     = $clog2(N_LAMP + 1)
) (
  input  logic [CW-1:0]     cnt,
  output logic [N_LAMP-1:0] lamp
);

  always_comb begin
    lamp = '0;
    for (int i = 0; i < N_LAMP; i++) begin
      lamp[i] = (cnt > CW'(i));
    end
  end

endmodule

// File: rtl/flasher_ctrl.sv
// Bound-flasher sequencer: walks phases 0..6, owns the lit-lamp count.
// Latency: flick sampled in idle moves to phase 1 on the same edge; lamp[0] one edge later.
// Backpressure: none; flick is level-sampled and never stalls the count.
//
// Ports:
//   clk      in   1       rising-edge clock
//   rst      in   1       synchronous active-high reset, overrides flick
//   flick    in   1       start request in idle, kickback request at bounds
//   current  out  3       phase code (0 idle, odd = turning on, even = turning off)
//   lamp     out  N_LAMP  thermometer vector of lit lamps
//   busy     out  1       high whenever current is not idle
module flasher_ctrl
  import flasher_pkg::*;
#(
  parameter int N_LAMP  = DEF_N_LAMP,
  parameter int BOUND_A = DEF_BOUND_A,
  parameter int BOUND_B = DEF_BOUND_B
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flick,
  output logic [2:0]        current,
  output logic [N_LAMP-1:0] lamp,
  output logic              busy
);

  localparam int CW = $clog2(N_LAMP + 1);

  localparam logic [CW-1:0] CNT_A   = CW'(BOUND_A);
  localparam logic [CW-1:0] CNT_B   = CW'(BOUND_B);
  localparam logic [CW-1:0] CNT_ALL = CW'(N_LAMP);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  phase_t        nxt;

  // State register: phase and count move together on every edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      current <= PH_IDLE;
      cnt     <= '0;
    end else begin
      current <= nxt;
      cnt     <= cnt_nx;
    end
  end

  // Next-state logic. Bound tests look at the updated count so the phase
  // turns on the same edge that the bound lamp lights or goes dark; the
  // bounds are always reached before the count could leave [0, N_LAMP].
  always_comb begin
    nxt    = current;
    cnt_nx = cnt;
    unique case (current)
      PH_IDLE: begin
        cnt_nx = '0;
        if (flick) nxt = PH_ON_A;
      end
      PH_ON_A: begin
        cnt_nx = cnt + CNT_ONE;
        if (cnt_nx == CNT_A) nxt = PH_OFF_A;
      end
      PH_OFF_A: begin
        cnt_nx = cnt - CNT_ONE;
        if (cnt_nx == '0) nxt = PH_ON_B;
      end
      PH_ON_B: begin
        cnt_nx = cnt + CNT_ONE;
        // Kickback wins over the normal bound exit.
        if (flick && (cnt_nx == CNT_A || cnt_nx == CNT_B)) nxt = PH_OFF_A;
        else if (cnt_nx == CNT_B)                          nxt = PH_OFF_B;
      end
      PH_OFF_B: begin
        cnt_nx = cnt - CNT_ONE;
        if (cnt_nx == CNT_A) nxt = PH_ON_ALL;
      end
      PH_ON_ALL: begin
        cnt_nx = cnt + CNT_ONE;
        if (flick && cnt_nx == CNT_B) nxt = PH_OFF_B;
        else if (cnt_nx == CNT_ALL)   nxt = PH_OFF_ALL;
      end
      PH_OFF_ALL: begin
        cnt_nx = cnt - CNT_ONE;
        if (cnt_nx == '0) nxt = PH_IDLE;
      end
      default: begin
        // Code 7 is unreachable; recover to a clean idle.
        nxt    = PH_IDLE;
        cnt_nx = '0;
      end
    endcase
  end

  // Output decode.
  always_comb begin
    busy = (current != PH_IDLE);
  end

  lamp_therm #(
    .N_LAMP (N_LAMP),
    .CW     (CW)
  ) u_therm (
    .cnt  (cnt),
    .lamp (lamp)
  );

endmodule

// File: tb/tb_flasher_ctrl.sv
// Self-checking bench for flasher_ctrl with default geometry (16 lamps, bounds 6/11).
module tb_flasher_ctrl;

  localparam int N  = 16;
  localparam int BA = 6;
  localparam int BB = 11;

  logic        clk;
  logic        rst;
  logic        flick;
  logic [2:0]  current;
  logic [15:0] lamp;
  logic        busy;

  flasher_ctrl #(.N_LAMP(N), .BOUND_A(BA), .BOUND_B(BB)) dut (
    .clk     (clk),
    .rst     (rst),
    .flick   (flick),
    .current (current),
    .lamp    (lamp),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase number plus lit count, driven by per-phase
  // direction and stopping-point tables.
  int m_ph  = 0;
  int m_cnt = 0;
  int dir_tab [0:6] = '{0, 1, -1, 1, -1, 1, -1};
  int tgt_tab [0:6] = '{0, BA, 0, BB, BA, N, 0};

  function automatic logic [15:0] lamp_of(input int c);
    logic [31:0] v;
    v = (32'd1 << c) - 32'd1;
    return v[15:0];
  endfunction

  task automatic model_step(input logic r, input logic f);
    int n;
    bit kick;
    if (r) begin
      m_ph = 0; m_cnt = 0;
    end else if (m_ph == 0) begin
      m_cnt = 0;
      if (f) m_ph = 1;
    end else begin
      n    = m_cnt + dir_tab[m_ph];
      kick = f && ((m_ph == 3 && (n == BA || n == BB)) || (m_ph == 5 && n == BB));
      if (kick)                  m_ph = m_ph - 1;
      else if (n == tgt_tab[m_ph]) m_ph = (m_ph == 6) ? 0 : m_ph + 1;
      m_cnt = n;
    end
  endtask

  task automatic check(input string name, input logic [2:0] ec, input logic [15:0] el,
                       input logic eb);
    n_vec++;
    if (current !== ec || lamp !== el || busy !== eb) begin
      n_err++;
      $display("FAIL %s @%0t: got current=%0d lamp=%h busy=%b, want current=%0d lamp=%h busy=%b",
               name, $time, current, lamp, busy, ec, el, eb);
    end
  endtask

  // One clock: drive inputs, advance model, sample after the edge, compare.
  task automatic step(input logic r, input logic f);
    rst   = r;
    flick = f;
    model_step(r, f);
    @(posedge clk);
    #1;
    check("model", 3'(m_ph), lamp_of(m_cnt), m_ph != 0);
  endtask

  task automatic run_to(input int ph, input int c, input string name);
    int g = 0;
    while (!(m_ph == ph && m_cnt == c) && g < 200) begin
      step(1'b0, 1'b0);
      g++;
    end
    if (!(m_ph == ph && m_cnt == c)) begin
      n_vec++; n_err++;
      $display("FAIL %s: timeout, model at phase=%0d cnt=%0d, want phase=%0d cnt=%0d",
               name, m_ph, m_cnt, ph, c);
    end
  endtask

  typedef struct {
    logic        r;
    logic        f;
    logic [2:0]  ec;
    logic [15:0] el;
    logic        eb;
  } vec_t;

  vec_t tbl [11];

  int          cp_j [6] = '{6, 12, 23, 28, 38, 54};
  logic [15:0] cp_l [6] = '{16'h003F, 16'h0000, 16'h07FF, 16'h003F, 16'hFFFF, 16'h0000};
  logic [2:0]  cp_c [6] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0};

  task automatic full_run(input bit hold_flick, input string name);
    logic f;
    step(1'b0, 1'b1);  // edge k
    check({name, "_start"}, 3'd1, 16'h0000, 1'b1);
    for (int j = 1; j <= 54; j++) begin
      f = hold_flick && (m_ph != 3) && (m_ph != 5);
      step(1'b0, f);
      for (int p = 0; p < 6; p++)
        if (cp_j[p] == j) check(name, cp_c[p], cp_l[p], cp_c[p] != 3'd0);
    end
  endtask

  initial begin
    rst   = 1'b1;
    flick = 1'b0;

    // Reset then a long idle stretch.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0);
      check("idle", 3'd0, 16'h0000, 1'b0);
    end

    // Start latency and first fill, with reset overriding flick.
    tbl[0]  = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 3'd0, 16'h0000, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 3'd1, 16'h0000, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 3'd1, 16'h0001, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 3'd1, 16'h0003, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 3'd1, 16'h0007, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 3'd1, 16'h000F, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 3'd1, 16'h001F, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 3'd2, 16'h003F, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 3'd2, 16'h001F, 1'b1};
    for (int i = 0; i < 11; i++) begin
      rst   = tbl[i].r;
      flick = tbl[i].f;
      model_step(tbl[i].r, tbl[i].f);
      @(posedge clk);
      #1;
      check("table", tbl[i].ec, tbl[i].el, tbl[i].eb);
    end

    // Full run with no kickback, then with flick held high where ignored.
    run_to(0, 0, "to_idle1");
    full_run(1'b0, "full_run");
    full_run(1'b1, "ignored_flick");
    step(1'b0, 1'b1);
    check("restart", 3'd1, 16'h0000, 1'b1);

    // Kickback at BOUND_A while climbing in phase 3.
    run_to(3, 5, "to_s3_5");
    step(1'b0, 1'b1);
    check("kick3", 3'd2, 16'h003F, 1'b1);
    for (int c = 5; c >= 0; c--) begin
      step(1'b0, 1'b0);
      check("kick3_desc", (c == 0) ? 3'd3 : 3'd2, lamp_of(c), 1'b1);
    end
    run_to(4, 11, "s3_reentry");
    check("s3_reentry", 3'd4, 16'h07FF, 1'b1);

    // Repeated kickback at BOUND_B in phase 5.
    for (int r = 0; r < 3; r++) begin
      run_to(5, 10, "to_s5_10");
      step(1'b0, 1'b1);
      check("kick5", 3'd4, 16'h07FF, 1'b1);
      for (int s = 0; s < 5; s++) step(1'b0, 1'b0);
      check("kick5_back", 3'd5, 16'h003F, 1'b1);
    end

    // Reset mid-run, then immediate restart.
    run_to(5, 9, "to_s5_9");
    step(1'b1, 1'b1);
    check("midrun_rst", 3'd0, 16'h0000, 1'b0);
    step(1'b0, 1'b1);
    check("post_rst_start", 3'd1, 16'h0000, 1'b1);

    // Random flick with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/flasher_ctrl.md
# flasher_ctrl

Sequencing controller for the bound-flasher lamp bank. It walks the 3-bit phase code (0–6) that the output decoder turns into the idle/increment/decrement command. It also owns the lamp-count register and the thermometer-coded lamp vector. It starts a run on `flick`, applies kickback when `flick` is re-asserted at the bound points, and returns to idle after the final turn-off.

## Interface
- `N_LAMP`, 16, number of lamps; 3 ≤ N_LAMP ≤ 255.
- `BOUND_A`, 6, lit-lamp count of the first bound (lamps 0..5); 0 < BOUND_A < BOUND_B.
- `BOUND_B`, 11, lit-lamp count of the second bound (lamps 0..10); BOUND_B < N_LAMP.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flick`  in  1  start/kickback request, synchronous to `clk`, level-sampled.
- `current`  out  3  phase code to the output decoder (0 idle; 1,3,5 turning on; 2,4,6 turning off).
- `lamp`  out  N_LAMP  thermometer vector; `lamp[i]` = 1 iff i < cnt.
- `busy`  out  1  high whenever `current` ≠ 0.

## Operation
- Internal register `cnt`, width `$clog2(N_LAMP+1)`, holds the number of lit lamps. All outputs are registered or decoded directly from `current`/`cnt`.
- Each non-idle phase changes `cnt` by exactly ±1 per cycle. `cnt_nx` is the updated value.
- Phase transitions are evaluated on `cnt_nx`, in the same edge as the count update.
- S0 IDLE: `cnt` held at 0. If `flick`=1, go to S1 with `cnt` unchanged.
- S1 (on): `cnt`+1. If `cnt_nx`==BOUND_A, go to S2.
- S2 (off): `cnt`−1. If `cnt_nx`==0, go to S3.
- S3 (on): `cnt`+1.
  - If `cnt_nx`∈{BOUND_A, BOUND_B} and `flick`=1, go to S2 (kickback).
  - Else if `cnt_nx`==BOUND_B, go to S4.
- S4 (off): `cnt`−1. If `cnt_nx`==BOUND_A, go to S5.
- S5 (on): `cnt`+1.
  - If `cnt_nx`==BOUND_B and `flick`=1, go to S4 (kickback).
  - Else if `cnt_nx`==N_LAMP, go to S6.
- S6 (off): `cnt`−1. If `cnt_nx`==0, go to S0.
- `flick` is ignored except in S0 and at the kickback points above. Holding `flick` high never stalls the count.
- Kickback priority: the kickback branch beats the normal bound branch. `cnt_nx` never leaves [0, N_LAMP]; there is no wrap-around.
- Codes 7 (unreachable) return to S0 with `cnt` cleared on the next edge.

## Timing
- Reset values: `current`=0, `cnt`=0, `lamp`=0, `busy`=0. `rst` takes effect on the next edge from any phase, mid-run included, and overrides `flick`.
- Start latency: `flick` sampled high in S0 at edge k. At edge k, `current` becomes 1 and `busy` becomes 1. At edge k+1, `lamp[0]` rises.
- Full run with no kickback, defaults, relative to edge k:
  - S1 through k+6 (`cnt`=6).
  - S2 through k+12 (`cnt`=0).
  - S3 through k+23 (`cnt`=11).
  - S4 through k+28 (`cnt`=6).
  - S5 through k+38 (`cnt`=16).
  - S6 through k+54, where `current` becomes 0.
  - `busy` is high for 54 cycles.
- `flick` high at k+54 restarts the run immediately, going to S1 at edge k+55.

## Structure
- Shared package `flasher_pkg`: phase localparams `PH_IDLE`..`PH_OFF_ALL` (3'd0..3'd6) and default `N_LAMP`/`BOUND_A`/`BOUND_B`. The output decoder imports the same phase codes.
- One sub-module, `lamp_therm`, maps `cnt` to the `lamp` vector (combinational, parameterised by N_LAMP).
- FSM and counter live in `flasher_ctrl`.

## Test plan
- Reset then idle: `rst`=1 for 2 cycles, then `flick`=0 for 20 cycles → `current`=0, `lamp`=16'h0000, `busy`=0 throughout.
- Full run: single-cycle `flick` at edge k → `lamp`=16'h003F at k+6, 16'h0000 at k+12, 16'h07FF at k+23, 16'h003F at k+28, 16'hFFFF at k+38, 16'h0000 and `current`=0 at k+54.
- S3 kickback at BOUND_A: `flick`=1 exactly when `cnt_nx`=6 in S3 → `current`=2 that edge, `lamp` descends 16'h001F…0. Re-entering S3 then proceeds normally.
- S5 kickback at BOUND_B: `flick`=1 when `cnt_nx`=11 in S5 → `current`=4, `cnt` descends to 6, re-enters S5. Repeating this loops indefinitely without overflow.
- Ignored flick: `flick` held high through S1, S2, S4, S6 → transitions identical to the full-run timing.
- Mid-run reset: assert `rst` at S5 with `cnt`=9 → next edge `current`=0, `lamp`=0, `busy`=0. `flick` high the cycle after release → `current`=1.
